// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   Parameterised ripple-carry adder with a combinational result, a registered
//   copy of that result, and a saturating counter of carry-out events.
//
// Parameters
//   WIDTH     operand width in bits (1..64)
//   CNT_W     width of the carry-out event counter (4..32)
//
// Ports
//   clk       sole clock, rising edge
//   rst_n     asynchronous active-low reset for all registers
//   a, b      unsigned addends
//   cin       carry-in
//   in_valid  qualifies a/b/cin for registered capture and counting
//   cnt_clr   synchronous clear of cout_cnt (wins over an increment)
//   sum       combinational (a+b+cin) mod 2^WIDTH
//   cout      combinational carry-out, bit WIDTH of a+b+cin
//   sum_q     registered sum
//   cout_q    registered carry-out
//   out_valid registered valid for sum_q/cout_q
//   cout_cnt  saturating count of valid samples that produced cout=1
//
// Valid semantics: there is no ready/back-pressure. A sample is accepted on
// every rising edge where in_valid=1; its result appears on sum_q/cout_q with
// out_valid=1 exactly one cycle later. When in_valid=0 the result registers
// hold and out_valid drops to 0 on the next cycle.
// -----------------------------------------------------------------------------
module full_adder #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             in_valid,
   input  logic             cnt_clr,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic [WIDTH-1:0] sum_q,
   output logic             cout_q,
   output logic             out_valid,
   output logic [CNT_W-1:0] cout_cnt
);

   // Carry chain: c[0] is the carry-in, c[WIDTH] is the carry-out.
   logic [WIDTH:0] c;

   assign c[0] = cin;

   // One 1-bit full-adder cell per bit position, rippling the carry upward.
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      logic p;
      assign p        = a[i] ^ b[i];
      assign sum[i]   = p ^ c[i];
      assign c[i+1]   = (a[i] & b[i]) | (c[i] & p);
   end

   assign cout = c[WIDTH];

   // Counter is all ones once it has saturated; further events are dropped.
   logic cnt_full;
   assign cnt_full = &cout_cnt;

   // Registered result path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q     <= '0;
         cout_q    <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            sum_q  <= sum;
            cout_q <= cout;
         end
      end
   end

   // Carry-out event counter; clear takes priority over a same-cycle event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cout_cnt <= '0;
      end else if (cnt_clr) begin
         cout_cnt <= '0;
      end else if (in_valid && cout && !cnt_full) begin
         cout_cnt <= cout_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_full_adder.sv
// -----------------------------------------------------------------------------
// tb_full_adder
//   Directed bench for full_adder. Two instances share clk/rst_n/cin/in_valid/
//   cnt_clr: u_dut1 (WIDTH=1) and u_dut8 (WIDTH=8), both with CNT_W=4 so the
//   counter saturates quickly. The clock can be gated off for the purely
//   combinational checks.
// -----------------------------------------------------------------------------
module tb_full_adder;

   // ---------------- clock / reset ----------------
   logic clk    = 1'b0;
   logic clk_en = 1'b0;
   logic rst_n  = 1'b0;

   initial begin
      forever begin
         #5;
         if (clk_en) clk = ~clk;
      end
   end

   // ---------------- stimulus / DUT signals ----------------
   logic       a1, b1;
   logic [7:0] a8, b8;
   logic       cin, in_valid, cnt_clr;

   logic       sum1, cout1, sum_q1, cout_q1, ov1;
   logic [3:0] cnt1;
   logic [7:0] sum8, sum_q8;
   logic       cout8, cout_q8, ov8;
   logic [3:0] cnt8;

   full_adder #(.WIDTH(1), .CNT_W(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin),
      .in_valid(in_valid), .cnt_clr(cnt_clr),
      .sum(sum1), .cout(cout1), .sum_q(sum_q1), .cout_q(cout_q1),
      .out_valid(ov1), .cout_cnt(cnt1)
   );

   full_adder #(.WIDTH(8), .CNT_W(4)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin),
      .in_valid(in_valid), .cnt_clr(cnt_clr),
      .sum(sum8), .cout(cout8), .sum_q(sum_q8), .cout_q(cout_q8),
      .out_valid(ov8), .cout_cnt(cnt8)
   );

   // ---------------- checking ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Hand-computed truth table for WIDTH=1, index = {a,b,cin}.
   logic exp1_sum  [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
   logic exp1_cout [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- directed sequence ----------------
   initial begin
      a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; b8 = 8'h00;
      cin = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0;

      // Reset state
      #1;
      check("rst_sum_q1",  sum_q1,  0);
      check("rst_cout_q1", cout_q1, 0);
      check("rst_ov1",     ov1,     0);
      check("rst_cnt1",    cnt1,    0);
      check("rst_sum_q8",  sum_q8,  0);
      check("rst_ov8",     ov8,     0);
      #1;
      rst_n = 1'b1;

      // WIDTH=1 truth table, clock stopped, each combination held 10 ns
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v   = 3'(i);
         a1  = v[2];
         b1  = v[1];
         cin = v[0];
         #10;
         check($sformatf("tt_sum_%0d", i),  sum1,  exp1_sum[i]);
         check($sformatf("tt_cout_%0d", i), cout1, exp1_cout[i]);
      end
      check("tt_ov_no_clk", ov1, 0);

      // WIDTH=8 boundary vectors
      a8 = 8'hFF; b8 = 8'h01; cin = 1'b0; #10;
      check("w8_ff01_sum", sum8, 8'h00);
      check("w8_ff01_cout", cout8, 1);
      a8 = 8'hFF; b8 = 8'hFF; cin = 1'b1; #10;
      check("w8_ffff1_sum", sum8, 8'hFF);
      check("w8_ffff1_cout", cout8, 1);
      a8 = 8'h3C; b8 = 8'h0F; cin = 1'b1; #10;
      check("w8_3c0f1_sum", sum8, 8'h4C);
      check("w8_3c0f1_cout", cout8, 0);
      a8 = 8'h80; b8 = 8'h80; cin = 1'b0; #10;
      check("w8_8080_sum", sum8, 8'h00);
      check("w8_8080_cout", cout8, 1);

      // Start the clock
      clk_en = 1'b1;

      // Registered capture: 1+1+0 on dut1, F0+20+0 on dut8
      @(negedge clk);
      a1 = 1'b1; b1 = 1'b1; cin = 1'b0; in_valid = 1'b1;
      a8 = 8'hF0; b8 = 8'h20;
      step();
      check("cap_sum_q1",  sum_q1,  0);
      check("cap_cout_q1", cout_q1, 1);
      check("cap_ov1",     ov1,     1);
      check("cap_cnt1",    cnt1,    1);
      check("cap_sum_q8",  sum_q8,  8'h10);
      check("cap_cout_q8", cout_q8, 1);
      check("cap_cnt8",    cnt8,    1);

      // in_valid=0: hold, out_valid drops
      @(negedge clk);
      in_valid = 1'b0; a1 = 1'b0; b1 = 1'b0; a8 = 8'h01; b8 = 8'h02;
      step();
      check("hold_ov1",     ov1,     0);
      check("hold_sum_q1",  sum_q1,  0);
      check("hold_cout_q1", cout_q1, 1);
      check("hold_sum_q8",  sum_q8,  8'h10);
      check("hold_cnt1",    cnt1,    1);

      // Valid sample without carry: counter unchanged
      @(negedge clk);
      in_valid = 1'b1; a1 = 1'b1; b1 = 1'b0; cin = 1'b0;
      step();
      check("nc_sum_q1",  sum_q1,  1);
      check("nc_cout_q1", cout_q1, 0);
      check("nc_cnt1",    cnt1,    1);
      check("nc_sum_q8",  sum_q8,  8'h03);

      // cnt_clr alone: counter cleared, result registers untouched
      @(negedge clk);
      in_valid = 1'b0; cnt_clr = 1'b1;
      step();
      check("clr_cnt1",    cnt1,   0);
      check("clr_cnt8",    cnt8,   0);
      check("clr_sum_q1",  sum_q1, 1);
      check("clr_ov1",     ov1,    0);
      check("clr_sum_q8",  sum_q8, 8'h03);

      // 20 consecutive carry-producing samples: saturate at 15
      @(negedge clk);
      cnt_clr = 1'b0; in_valid = 1'b1;
      a1 = 1'b1; b1 = 1'b1; cin = 1'b1;
      a8 = 8'h80; b8 = 8'h80;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (i == 14) check("sat_cnt1_14", cnt1, 14);
         if (i == 15) check("sat_cnt1_15", cnt1, 15);
      end
      check("sat_cnt1_20", cnt1, 15);
      check("sat_cnt8_20", cnt8, 15);
      check("sat_sum_q8",  sum_q8, 8'h01);

      // Clear together with a valid carry event: clear wins
      @(negedge clk);
      cnt_clr = 1'b1;
      step();
      check("clrpri_cnt1", cnt1, 0);
      check("clrpri_cnt8", cnt8, 0);
      check("clrpri_ov1",  ov1,  1);
      @(negedge clk);
      cnt_clr = 1'b0;
      step();
      check("post_clr_cnt1", cnt1, 1);

      // Asynchronous reset mid-operation while out_valid=1
      check("pre_rst_ov1", ov1, 1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      a1 = 1'b1; b1 = 1'b0; cin = 1'b1;
      a8 = 8'h7F; b8 = 8'h01;
      #1;
      check("arst_sum_q1",  sum_q1,  0);
      check("arst_cout_q1", cout_q1, 0);
      check("arst_ov1",     ov1,     0);
      check("arst_cnt1",    cnt1,    0);
      check("arst_sum_q8",  sum_q8,  0);
      check("arst_sum1",    sum1,    0);
      check("arst_cout1",   cout1,   1);
      check("arst_sum8",    sum8,    8'h81);
      check("arst_cout8",   cout8,   0);
      step();
      check("arst_hold_ov1", ov1, 0);

      // Release reset between edges with no valid input: no stale pulse
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b1;
      step();
      check("rel_ov1",   ov1,    0);
      check("rel_sum_q8", sum_q8, 0);

      // Normal operation resumes
      @(negedge clk);
      in_valid = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin = 1'b1;
      step();
      check("res_ov8",     ov8,     1);
      check("res_sum_q8",  sum_q8,  8'h00);
      check("res_cout_q8", cout_q8, 1);
      check("res_cnt8",    cnt8,    1);

      @(negedge clk);
      in_valid = 1'b0;
      clk_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
